pulse_handshake_tx: RTL and testbench
=====================================

# pulse_handshake_tx

Single-clock transmitter end of a 2-phase (toggle) request/acknowledge pulse-crossing channel. Accepts single-cycle event pulses in its own clock domain and queues them in a saturating pending counter. Launches each event as one toggle of `req_tgl` toward a receiver in another clock domain, and waits for the receiver's echoed acknowledge toggle before launching the next. Unlike a free-running toggle crossing, no event is lost when events arrive faster than the receiver can absorb them, up to the counter depth.

## Interface
- `CNT_W`, default 4: pending-counter width; queue depth is 2^CNT_W−1 events.
- `SYNC_STAGES`, default 2 (minimum 2): flop stages synchronizing `ack_tgl_async`.

- `clk`  in  1  block clock; all state is updated on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pulse_in`  in  1  event strobe; every cycle it is high counts as one event.
- `ack_tgl_async`  in  1  acknowledge toggle from the receiver; asynchronous to `clk`.
- `ovf_clr`  in  1  clears the sticky `overflow` flag.
- `req_tgl`  out  1  request toggle to the receiver; flips exactly once per launched event.
- `pending`  out  CNT_W  number of queued events not yet launched.
- `busy`  out  1  high while a launched event is awaiting acknowledge.
- `done`  out  1  one-cycle strobe when an acknowledge is received.
- `overflow`  out  1  sticky flag: at least one event was dropped.

## Operation
- All outputs are registered. Reset values: `req_tgl`=0, `pending`=0, `busy`=0, `done`=0, `overflow`=0, state=IDLE. Every synchronizer flop also resets to 0.
- Synchronizer: `ack_tgl_async` passes through SYNC_STAGES flops; the last stage is `ack_s`. "Acked" means `ack_s == req_tgl`.
- Two states, IDLE and WAIT_ACK. `busy` = (state == WAIT_ACK).
- Behaviour in IDLE:
  - Launch condition: `pending != 0` or `pulse_in`.
  - On launch: flip `req_tgl` and go to WAIT_ACK.
  - Next `pending` = `pending` + `pulse_in` − 1, floored at 0. A pulse arriving with `pending`=0 launches directly and is never counted.
- Behaviour in WAIT_ACK while not acked: if `pulse_in`, increment `pending`.
- Behaviour in WAIT_ACK when acked: set `done`=1 for one cycle.
  - If `pending != 0` or `pulse_in`: relaunch on the same edge. Flip `req_tgl`, stay in WAIT_ACK, and update `pending` = `pending` + `pulse_in` − 1.
  - Otherwise go to IDLE.
- Saturation: when `pulse_in` arrives, no launch consumes it this cycle, and `pending` = 2^CNT_W−1, the event is dropped. `pending` holds and `overflow` is set to 1.
- `overflow` clears only on `ovf_clr`. If a set and `ovf_clr` occur in the same cycle, `overflow` stays 1 (set wins).
- Toggle ordering: `req_tgl` never flips while un-acked. At most one request is outstanding at any time.
- Reset mid-operation: all queued and in-flight events are discarded. The receiver must be reset in the same window so that its ack toggle returns to 0. Otherwise the first post-reset launch mis-pairs with a stale acknowledge.

## Timing
- Launch latency: `pulse_in` high in cycle n with IDLE and `pending`=0 causes `req_tgl` to flip and `busy`=1 from cycle n+1.
- Ack latency: an `ack_tgl_async` change that is stable before edge k sets `ack_s` after edge k+SYNC_STAGES−1. `done` then pulses, and any relaunch happens, at edge k+SYNC_STAGES.
- Relaunch adds zero idle cycles. Throughput is one event per round trip: receiver latency + SYNC_STAGES + 1 cycles.
- `pending` reflects the edge-updated count. `done` is high for exactly one cycle per acknowledge.

## Test plan
- Reset: hold `rst`=1 for 2 cycles while `pulse_in`=1 and `ack_tgl_async` toggles → all outputs 0 and state IDLE after release.
- Single event (CNT_W=4, SYNC_STAGES=2): `pulse_in` at cycle 0 → `req_tgl`=1 and `busy`=1 at cycle 1. Drive `ack_tgl_async`=1 before edge 6 → `done`=1 and `busy`=0 at cycle 8; `done`=0 at cycle 9.
- Burst: `pulse_in` at cycles 0, 1, 2 → `pending`=2 at cycle 3. Echo each `req_tgl` flip on the ack input after 3 cycles → exactly 3 `req_tgl` flips (final value 1) and 3 `done` strobes. Each relaunch coincides with its `done`; `pending` ends at 0.
- Overflow: hold the ack constant and pulse 17 consecutive cycles → 1 launched event, `pending`=15, `overflow`=1 after the 17th pulse. Assert `ovf_clr` → `overflow`=0 and `pending` still 15.
- Simultaneous events: in WAIT_ACK with `pending`=0, `pulse_in` in the same cycle as the ack match → `done`=1, `req_tgl` flips, `busy` stays 1, `pending` stays 0.
- Reset mid-operation: in WAIT_ACK with `pending`=5, assert `rst` for 1 cycle and reset the receiver at the same time → next cycle `pending`=0, `busy`=0, `req_tgl`=0. A following `pulse_in` completes a normal single-event handshake.

Source files
------------

// File: rtl/pulse_handshake_tx.sv
// pulse_handshake_tx
//
// Transmitter end of a 2-phase (toggle) request/acknowledge pulse crossing.
// Single-cycle event pulses are queued in a saturating pending counter and
// launched one at a time as a single flip of req_tgl. The next event is not
// launched until the receiver's acknowledge toggle, synchronized into this
// clock domain, matches req_tgl again.
//
// Parameters
//   CNT_W        pending-counter width; queue depth is 2^CNT_W-1 events
//   SYNC_STAGES  flop stages on ack_tgl_async (minimum 2)
//
// Ports
//   clk            in   block clock, rising edge
//   rst            in   synchronous active-high reset
//   pulse_in       in   event strobe, one event per high cycle
//   ack_tgl_async  in   acknowledge toggle from the receiver domain
//   ovf_clr        in   clears the sticky overflow flag
//   req_tgl        out  request toggle, one flip per launched event
//   pending        out  queued events not yet launched
//   busy           out  a launched event is awaiting acknowledge
//   done           out  one-cycle strobe per received acknowledge
//   overflow       out  sticky: at least one event was dropped

module pulse_handshake_tx #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_tgl_async,
  input  logic             ovf_clr,
  output logic             req_tgl,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t               state;
  state_t               state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                 ack_s;
  logic                 acked;
  logic                 work;
  logic                 fire;
  logic                 drop;
  logic                 req_nxt;
  logic [CNT_W-1:0]     pend_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 ovf_nxt;

  // Pending-count update. A launch (dec) consumes either a queued event or
  // the arriving pulse, so it never underflows; the floor at 0 only guards
  // the unreachable case. Without a launch an arriving pulse is queued
  // unless the counter is full, in which case it is reported as dropped.
  // Returns {drop, next_count}.
  function automatic logic [CNT_W:0] pend_step(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W-1:0] res;
    logic             dropped;
    res     = cnt;
    dropped = 1'b0;
    if (dec) begin
      if (inc)               res = cnt;
      else if (cnt != '0)    res = cnt - CNT_ONE;
      else                   res = '0;
    end else if (inc) begin
      if (cnt == CNT_MAX)    dropped = 1'b1;
      else                   res = cnt + CNT_ONE;
    end
    return {dropped, res};
  endfunction

  // Acknowledge synchronizer; ack_s is the last stage.
  always_ff @(posedge clk) begin
    if (rst) ack_sync <= '0;
    else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl_async};
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];
  assign acked = (ack_s == req_tgl);
  assign work  = (pending != '0) || pulse_in;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_tgl  <= 1'b0;
      pending  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_tgl  <= req_nxt;
      pending  <= pend_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      overflow <= ovf_nxt;
    end
  end

  // Next state. In WAIT_ACK an acknowledge with more work relaunches on the
  // same edge and stays put, so back-to-back events add no idle cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (work) state_nxt = WAIT_ACK;
      WAIT_ACK: if (acked && !work) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    fire     = 1'b0;
    done_nxt = 1'b0;
    unique case (state)
      IDLE:     fire = work;
      WAIT_ACK: begin
        done_nxt = acked;
        fire     = acked && work;
      end
      default:  fire = 1'b0;
    endcase
    req_nxt          = fire ? ~req_tgl : req_tgl;
    {drop, pend_nxt} = pend_step(pending, pulse_in, fire);
    // Set wins over a simultaneous clear.
    ovf_nxt          = drop | (overflow & ~ovf_clr);
    busy_nxt         = (state_nxt == WAIT_ACK);
  end

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Directed testbench for pulse_handshake_tx (CNT_W=4, SYNC_STAGES=2).
// Inputs change 1 time unit after each rising edge; outputs are sampled
// at the same point, away from the active edge.

module tb_pulse_handshake_tx;

  localparam int CNT_W = 4;
  localparam int SS    = 2;

  logic             clk;
  logic             rst;
  logic             pulse_in;
  logic             ack_tgl_async;
  logic             ovf_clr;
  logic             req_tgl;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             done;
  logic             overflow;

  int n_cmp;
  int n_err;

  pulse_handshake_tx #(.CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .clk           (clk),
    .rst           (rst),
    .pulse_in      (pulse_in),
    .ack_tgl_async (ack_tgl_async),
    .ovf_clr       (ovf_clr),
    .req_tgl       (req_tgl),
    .pending       (pending),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic chk_all(input string tag, input logic r, input logic [CNT_W-1:0] p,
                         input logic b, input logic d, input logic o);
    chk({tag, ".req"},  32'(req_tgl),  32'(r));
    chk({tag, ".pend"}, 32'(pending),  32'(p));
    chk({tag, ".busy"}, 32'(busy),     32'(b));
    chk({tag, ".done"}, 32'(done),     32'(d));
    chk({tag, ".ovf"},  32'(overflow), 32'(o));
  endtask

  task automatic do_reset();
    rst = 1'b1; ack_tgl_async = 1'b0; pulse_in = 1'b0; ovf_clr = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic prev_req;
    logic echo_val;
    int   echo_cyc;
    int   flips;
    int   dones;
    int   relaunch_done;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; pulse_in = 1'b1; ack_tgl_async = 1'b0; ovf_clr = 1'b0;

    // Reset held 2 cycles with pulse_in high and ack toggling.
    tick();
    ack_tgl_async = 1'b1;
    tick();
    chk_all("rst_hold", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; pulse_in = 1'b0; ack_tgl_async = 1'b0;
    tick();
    chk_all("rst_rel", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Single event: pulse in cycle 0, ack driven in cycle 5 (before edge 6).
    pulse_in = 1'b1;
    tick();                                   // cycle 1
    pulse_in = 1'b0;
    chk_all("single_c1", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();                        // cycle 5
    ack_tgl_async = 1'b1;
    tick();                                   // cycle 6
    tick();                                   // cycle 7
    chk("single_c7.done", 32'(done), 32'd0);
    chk("single_c7.busy", 32'(busy), 32'd1);
    tick();                                   // cycle 8
    chk_all("single_c8", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();                                   // cycle 9
    chk("single_c9.done", 32'(done), 32'd0);

    // Burst of three pulses, receiver echoes each flip 3 cycles later.
    do_reset();
    pulse_in      = 1'b1;                     // cycle 0
    prev_req      = 1'b0;
    echo_cyc      = -1;
    echo_val      = 1'b0;
    flips         = 0;
    dones         = 0;
    relaunch_done = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      pulse_in = (c <= 2);
      if (c == 3) chk("burst_c3.pend", 32'(pending), 32'd2);
      if (req_tgl !== prev_req) begin
        flips++;
        echo_cyc = c + 3;
        echo_val = req_tgl;
        if (done) relaunch_done++;
      end
      if (done) dones++;
      prev_req = req_tgl;
      if (c == echo_cyc) ack_tgl_async = echo_val;
    end
    chk("burst.flips",    32'(flips),         32'd3);
    chk("burst.dones",    32'(dones),         32'd3);
    chk("burst.relaunch", 32'(relaunch_done), 32'd2);
    chk_all("burst_end", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

    // Overflow: ack held at 1, 17 consecutive pulses from IDLE with req=1.
    for (int i = 0; i < 17; i++) begin
      pulse_in = 1'b1;
      tick();
      if (i == 0)  chk_all("ovf_first", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      if (i == 15) chk_all("ovf_full", 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
    end
    pulse_in = 1'b0;
    chk_all("ovf_drop", 1'b0, 4'd15, 1'b1, 1'b0, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk_all("ovf_clr", 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
    // Drop and clear in the same cycle: set wins.
    ovf_clr = 1'b1; pulse_in = 1'b1;
    tick();
    ovf_clr = 1'b0; pulse_in = 1'b0;
    chk("ovf_setwins.ovf",  32'(overflow), 32'd1);
    chk("ovf_setwins.pend", 32'(pending),  32'd15);

    // Simultaneous pulse and ack match in WAIT_ACK with pending=0.
    do_reset();
    pulse_in = 1'b1;
    tick();                                   // launch, req=1
    pulse_in = 1'b0;
    ack_tgl_async = 1'b1;
    tick();
    tick();                                   // ack_s now 1
    chk("sim_pre.done", 32'(done), 32'd0);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    chk_all("sim", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);

    // Reset mid-operation with pending=5 (ack_s=1, req=0: waiting).
    repeat (5) begin
      pulse_in = 1'b1;
      tick();
    end
    pulse_in = 1'b0;
    chk_all("midrst_pre", 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    rst = 1'b1; ack_tgl_async = 1'b0;
    tick();
    rst = 1'b0;
    chk_all("midrst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    chk_all("post_launch", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    ack_tgl_async = 1'b1;
    tick();
    tick();
    chk("post_wait.done", 32'(done), 32'd0);
    tick();
    chk_all("post_done", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("post_after.done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
